// File: rtl/dual_fetch_buffer.sv
// IF/ID producer for a 2-way core: owns the PC, fetches aligned instruction pairs
// and queues them for decode. Optional FETCH_STATS_EN adds stall/flush counters.
module dual_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [63:0]              imem_addr,
  input  logic [31:0]              imem_instr1,
  input  logic [31:0]              imem_instr2,
  input  logic                     redirect_en,
  input  logic [63:0]              redirect_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr1,
  output logic [31:0]              out_instr2,
  output logic                     out_slot1_vld,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]              stat_stall_cnt,
  output logic [31:0]              stat_flush_cnt
`endif
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // PC is kept word-granular; bits [1:0] of a redirect target are dropped.
  logic [63:2]   r_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [63:3]   r_pc_mem [DEPTH];
  logic [31:0]   r_i1_mem [DEPTH];
  logic [31:0]   r_i2_mem [DEPTH];
  logic          r_s1_mem [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic          w_slot1_vld;
  logic          w_unused;

  assign w_unused    = &{1'b0, redirect_addr[1:0]};
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = !w_empty && out_ready;
  assign w_push      = !redirect_en && (!w_full || w_pop);
  assign w_slot1_vld = ~r_pc[2];

  assign imem_addr = {r_pc[63:3], 3'b000};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC[63:2];
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_en) begin
      // Flush wins over any handshake in the same cycle.
      r_pc     <= redirect_addr[63:2];
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= {r_pc[63:3] + 61'd1, 1'b0};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Per-entry storage; contents need no reset because reads are gated by count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == PW'(gi))) begin
          r_pc_mem[gi] <= r_pc[63:3];
          r_i1_mem[gi] <= w_slot1_vld ? imem_instr1 : NOP;
          r_i2_mem[gi] <= imem_instr2;
          r_s1_mem[gi] <= w_slot1_vld;
        end
      end
    end
  endgenerate

  always_comb begin
    out_valid     = 1'b0;
    out_pc        = '0;
    out_instr1    = NOP;
    out_instr2    = NOP;
    out_slot1_vld = 1'b0;
    if (!w_empty) begin
      out_valid     = 1'b1;
      out_pc        = {r_pc_mem[r_rd_ptr], 3'b000};
      out_instr1    = r_i1_mem[r_rd_ptr];
      out_instr2    = r_i2_mem[r_rd_ptr];
      out_slot1_vld = r_s1_mem[r_rd_ptr];
    end
  end

  assign count = r_count;

`ifdef FETCH_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_empty && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (redirect_en && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stat_stall_cnt = r_stall_cnt;
  assign stat_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_dual_fetch_buffer.sv
// Scoreboard bench for dual_fetch_buffer: a queue-level model predicts pushed pairs,
// a negedge monitor pops and compares on every handshake.
module tb_dual_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr1;
  logic [31:0] imem_instr2;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_addr = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [31:0] out_instr1;
  logic [31:0] out_instr2;
  logic        out_slot1_vld;
  logic [2:0]  count;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_flush_cnt;
`endif

  always #5 clk = ~clk;

  // Instruction memory returns address tags.
  assign imem_instr1 = imem_addr[31:0];
  assign imem_instr2 = imem_addr[31:0] + 32'd4;

  dual_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr1   (imem_instr1),
    .imem_instr2   (imem_instr2),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr1    (out_instr1),
    .out_instr2    (out_instr2),
    .out_slot1_vld (out_slot1_vld),
    .count         (count)
`ifdef FETCH_STATS_EN
    ,
    .stat_stall_cnt(stat_stall_cnt),
    .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        s1;
  } ent_t;

  ent_t        exp_q[$];
  logic [63:0] m_pc = RESET_PC;
  longint      m_stall = 0;
  longint      m_flush = 0;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference model at the edge.
  task automatic cyc(input logic r, input logic rdy, input logic re, input logic [63:0] ra);
    ent_t e;
    logic [63:0] base;
    rst_n = r; out_ready = rdy; redirect_en = re; redirect_addr = ra;
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
      m_pc = RESET_PC;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (exp_q.size() > 0 && !rdy) m_stall++;
      if (re) begin
        m_flush++;
        exp_q.delete();
        m_pc = ra & ~64'h3;
      end else if (exp_q.size() < DEPTH) begin
        base = m_pc & ~64'h7;
        e.pc = base;
        e.s1 = ~m_pc[2];
        e.i1 = e.s1 ? base[31:0] : NOP;
        e.i2 = base[31:0] + 32'd4;
        exp_q.push_back(e);
        m_pc = base + 64'd8;
      end
    end
    #1;
  endtask

  // Monitor: state checks every cycle, content checks on each accepted pair.
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t e;
      check("count", {61'b0, count}, 64'(exp_q.size()));
      check("out_valid", {63'b0, out_valid}, {63'b0, exp_q.size() != 0});
      check("imem_addr", imem_addr, m_pc & ~64'h7);
`ifdef FETCH_STATS_EN
      check("stat_stall", {32'b0, stat_stall_cnt}, 64'(m_stall));
      check("stat_flush", {32'b0, stat_flush_cnt}, 64'(m_flush));
`endif
      if (exp_q.size() == 0) begin
        check("empty_pair", {out_pc, out_instr1, out_instr2, 31'b0, out_slot1_vld},
              {64'h0, NOP, NOP, 32'h0});
      end else if (rst_n && !redirect_en && out_ready) begin
        e = exp_q.pop_front();
        check("pop_pc", out_pc, e.pc);
        check("pop_instr", {out_instr1, out_instr2}, {e.i1, e.i2});
        check("pop_slot1", {63'b0, out_slot1_vld}, {63'b0, e.s1});
        $display("pop pc=%h i1=%h i2=%h s1=%0d", out_pc, out_instr1, out_instr2, out_slot1_vld);
      end
    end
  end

  initial begin
    logic [63:0] ra;
    cyc(0, 1, 0, 0);
    mon_en = 1'b1;
    cyc(0, 1, 0, 0);
    repeat (6) cyc(1, 1, 0, 0);

    // Fill with decode stalled, then stream while full.
    cyc(0, 0, 0, 0);
    repeat (6) cyc(1, 0, 0, 0);
    check("full_count", {61'b0, count}, 64'd4);
    check("full_addr", imem_addr, 64'h20);
    cyc(1, 1, 0, 0);
    check("full_pushpop_count", {61'b0, count}, 64'd4);
    repeat (5) cyc(1, 1, 0, 0);

    // Redirect to a 4-mod-8 target with three entries queued.
    cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    check("pre_redir_count", {61'b0, count}, 64'd3);
    cyc(1, 0, 1, 64'h104);
    check("redir_flush", {61'b0, count, 63'b0, out_valid}, 128'h0);
    check("redir_addr", imem_addr, 64'h100);
    cyc(1, 0, 0, 0);
    check("redir_head", {out_pc, out_instr1, 31'b0, out_slot1_vld}, {64'h100, NOP, 32'h0});
    cyc(1, 1, 0, 0);
    check("redir_next", {out_pc, 63'b0, out_slot1_vld}, {64'h108, 64'h1});

    // 64-bit PC wrap and reset overriding a redirect.
    cyc(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    check("wrap_pre", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    cyc(1, 1, 0, 0);
    check("wrap_post", imem_addr, 64'h0);
    cyc(0, 1, 1, 64'h500);
    check("rst_over_redir", imem_addr, RESET_PC);

    // Five stalled cycles followed by two redirects.
    cyc(1, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 64'h40);
    cyc(1, 1, 1, 64'h80);
`ifdef FETCH_STATS_EN
    check("stats_stall5", {32'b0, stat_stall_cnt}, 64'd5);
    check("stats_flush2", {32'b0, stat_flush_cnt}, 64'd2);
`endif

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      ra = {$urandom, $urandom};
      if ($urandom_range(3) == 0) ra = 64'hFFFF_FFFF_FFFF_FF00 | (ra & 64'hFF);
      cyc(($urandom_range(99) != 0), ($urandom_range(9) < 7), ($urandom_range(19) == 0), ra);
    end
    cyc(1, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
